alu_ctrl_mc: RTL and testbench

ALU control decoder for the EX stage with a built-in sequencer for multi-cycle multiply/divide. It decodes ALUOp/funct into the ALU operation code. For MULT/DIV it also issues a start pulse to the multi-cycle unit, holds the pipeline with a stall for a parametrised latency, and signals completion. It sits between the ID/EX pipeline register and the ALU/multi-cycle unit and drives the hazard unit's stall input.

---
 rtl/alu_ctrl_mc.sv | 116 +++++++++++
 tb/tb_alu_ctrl_mc.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_mc.sv
// rtl/alu_ctrl_mc.sv - EX-stage ALU control decoder with multi-cycle mul/div sequencer
// Decodes ALUOp/funct into the ALU opcode and stalls the pipeline while mul/div runs.
module alu_ctrl_mc #(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 16,
  parameter int CTRL_W  = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic              flush_i,
  input  logic [5:0]        funct_i,
  input  logic [2:0]        ALUOp_i,
  output logic [CTRL_W-1:0] ALUCtrl_o,
  output logic              illegal_o,
  output logic              mc_start_o,
  output logic              mc_op_o,
  output logic              stall_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);
  localparam logic [CNT_W-1:0] MUL_INIT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIV_LAT - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mc_op_q, mc_op_d;

  logic [3:0] ctrl;
  logic       unknown_funct;
  logic       is_mc;
  logic       start;

  always_comb begin
    ctrl          = 4'b0010;
    unknown_funct = 1'b0;
    unique case (ALUOp_i)
      3'b000: ctrl = 4'b0010;
      3'b001: ctrl = 4'b0111;
      3'b100: ctrl = 4'b0110;
      3'b010: begin
        unique case (funct_i)
          6'b100000, 6'b001000: ctrl = 4'b0010;
          6'b100010: ctrl = 4'b0110;
          6'b100100: ctrl = 4'b0000;
          6'b100101: ctrl = 4'b0001;
          6'b100111: ctrl = 4'b1100;
          6'b101010: ctrl = 4'b0111;
          6'b011000: ctrl = 4'b1000;
          6'b011010: ctrl = 4'b1001;
          default: begin
            ctrl          = 4'b0010;
            unknown_funct = 1'b1;
          end
        endcase
      end
      default: ctrl = 4'b0010;
    endcase
  end

  assign ALUCtrl_o = CTRL_W'(ctrl);
  assign illegal_o = unknown_funct & valid_i;
  assign is_mc     = (ALUOp_i == 3'b010) && ((funct_i == 6'b011000) || (funct_i == 6'b011010));
  assign start     = (state_q == S_IDLE) && valid_i && is_mc && !flush_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mc_op_d = mc_op_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          mc_op_d = funct_i[1];
          cnt_d   = funct_i[1] ? DIV_INIT : MUL_INIT;
          // A single-cycle op skips RUN and finishes on the next edge.
          if (funct_i[1] ? (DIV_LAT > 1) : (MUL_LAT > 1)) state_d = S_RUN;
          else state_d = S_DONE;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mc_op_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mc_op_q <= mc_op_d;
    end
  end

  assign mc_start_o = start;
  assign stall_o    = start || ((state_q == S_RUN) && !flush_i);
  assign busy_o     = (state_q != S_IDLE);
  assign done_o     = (state_q == S_DONE) && !flush_i;
  assign mc_op_o    = mc_op_q;

endmodule

// File: tb/tb_alu_ctrl_mc.sv
// tb/tb_alu_ctrl_mc.sv - self-checking bench for alu_ctrl_mc
// Decode table sweep plus hand-written multi-cycle, flush and reset sequences.
module tb_alu_ctrl_mc;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid, flush;
  logic [5:0] funct;
  logic [2:0] aluop;
  logic [3:0] ctrl, ctrl1;
  logic       ill, start, mc_op, stall, busy, done;
  logic       ill1, start1, mc_op1, stall1, busy1, done1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int done_q[$];
  logic [4:0] dec_q[$];

  alu_ctrl_mc #(.MUL_LAT(4), .DIV_LAT(16), .CTRL_W(4)) u_dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .flush_i(flush), .funct_i(funct),
    .ALUOp_i(aluop), .ALUCtrl_o(ctrl), .illegal_o(ill), .mc_start_o(start),
    .mc_op_o(mc_op), .stall_o(stall), .busy_o(busy), .done_o(done)
  );

  alu_ctrl_mc #(.MUL_LAT(1), .DIV_LAT(2), .CTRL_W(4)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .flush_i(flush), .funct_i(funct),
    .ALUOp_i(aluop), .ALUCtrl_o(ctrl1), .illegal_o(ill1), .mc_start_o(start1),
    .mc_op_o(mc_op1), .stall_o(stall1), .busy_o(busy1), .done_o(done1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0] aluop;
    logic [5:0] funct;
    logic       valid;
    logic [3:0] ctrl;
    logic       ill;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Any done_o seen must match the cycle predicted when the op was started.
  task automatic watch_done();
    int exp_cyc;
    if (done === 1'b1) begin
      if (done_q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        exp_cyc = done_q.pop_front();
        chk("done_cycle", cyc, exp_cyc);
      end
    end
  endtask

  task automatic drive_mc(input logic dv);
    valid = 1'b1;
    aluop = 3'b010;
    funct = dv ? 6'b011010 : 6'b011000;
    flush = 1'b0;
  endtask

  task automatic mc_seq(input logic dv, input int lat);
    int t0;
    @(negedge clk);
    drive_mc(dv);
    t0 = cyc;
    done_q.push_back(t0 + lat);
    for (int k = 0; k <= lat; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      chk("mc_start", int'(start), (k == 0) ? 1 : 0);
      chk("stall", int'(stall), (k < lat) ? 1 : 0);
      chk("busy", int'(busy), (k >= 1) ? 1 : 0);
      if (k >= 1) chk("mc_op", int'(mc_op), int'(dv));
      watch_done();
    end
  endtask

  task automatic idle_check();
    @(negedge clk);
    valid = 1'b0;
    flush = 1'b0;
    #1;
    chk("idle_busy", int'(busy), 0);
    chk("idle_stall", int'(stall), 0);
    watch_done();
  endtask

  task automatic do_reset();
    @(negedge clk);
    valid = 1'b0;
    flush = 1'b0;
    rst   = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [4:0] exp_dec;
    rst   = 1'b1;
    valid = 1'b0;
    flush = 1'b0;
    funct = 6'b000000;
    aluop = 3'b000;

    vecs[0]  = '{3'b000, 6'b000000, 1'b1, 4'b0010, 1'b0};
    vecs[1]  = '{3'b001, 6'b000000, 1'b1, 4'b0111, 1'b0};
    vecs[2]  = '{3'b100, 6'b000000, 1'b1, 4'b0110, 1'b0};
    vecs[3]  = '{3'b010, 6'b100000, 1'b1, 4'b0010, 1'b0};
    vecs[4]  = '{3'b010, 6'b001000, 1'b1, 4'b0010, 1'b0};
    vecs[5]  = '{3'b010, 6'b100010, 1'b1, 4'b0110, 1'b0};
    vecs[6]  = '{3'b010, 6'b100100, 1'b1, 4'b0000, 1'b0};
    vecs[7]  = '{3'b010, 6'b100101, 1'b1, 4'b0001, 1'b0};
    vecs[8]  = '{3'b010, 6'b100111, 1'b1, 4'b1100, 1'b0};
    vecs[9]  = '{3'b010, 6'b101010, 1'b1, 4'b0111, 1'b0};
    vecs[10] = '{3'b010, 6'b011000, 1'b1, 4'b1000, 1'b0};
    vecs[11] = '{3'b010, 6'b011010, 1'b1, 4'b1001, 1'b0};
    vecs[12] = '{3'b010, 6'b111111, 1'b1, 4'b0010, 1'b1};
    vecs[13] = '{3'b010, 6'b111111, 1'b0, 4'b0010, 1'b0};
    vecs[14] = '{3'b011, 6'b111111, 1'b1, 4'b0010, 1'b0};
    vecs[15] = '{3'b111, 6'b011000, 1'b1, 4'b0010, 1'b0};

    // Reset state with decode still live
    #12;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_stall", int'(stall), 0);
    chk("rst_start", int'(start), 0);
    chk("rst_mc_op", int'(mc_op), 0);
    chk("rst_ctrl", int'(ctrl), 2);
    @(negedge clk);
    rst = 1'b0;

    // Decode sweep; the mul/div rows kick the sequencer but decode is unaffected
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      aluop = vecs[i].aluop;
      funct = vecs[i].funct;
      valid = vecs[i].valid;
      dec_q.push_back({vecs[i].ctrl, vecs[i].ill});
      #1;
      exp_dec = dec_q.pop_front();
      chk($sformatf("dec_ctrl[%0d]", i), int'(ctrl), int'(exp_dec[4:1]));
      chk($sformatf("dec_ill[%0d]", i), int'(ill), int'(exp_dec[0]));
    end
    do_reset();

    // MULT, then DIV followed back-to-back by MULT
    mc_seq(1'b0, 4);
    idle_check();
    mc_seq(1'b1, 16);
    mc_seq(1'b0, 4);
    idle_check();

    // Non-mc instruction: no stall, no start
    @(negedge clk);
    valid = 1'b1; aluop = 3'b010; funct = 6'b100000;
    #1;
    chk("nonmc_stall", int'(stall), 0);
    chk("nonmc_start", int'(start), 0);

    // Flush at T0+2 of a MULT
    @(negedge clk);
    drive_mc(1'b0);
    #1;
    chk("fl_start", int'(start), 1);
    @(negedge clk);
    #1;
    chk("fl_stall1", int'(stall), 1);
    @(negedge clk);
    flush = 1'b1;
    #1;
    chk("fl_stall", int'(stall), 0);
    chk("fl_done", int'(done), 0);
    chk("fl_start2", int'(start), 0);
    for (int k = 0; k < 6; k++) idle_check();

    // Flush coincident with a start
    @(negedge clk);
    drive_mc(1'b1);
    flush = 1'b1;
    #1;
    chk("flst_start", int'(start), 0);
    chk("flst_stall", int'(stall), 0);
    idle_check();
    chk("flst_mc_op", int'(mc_op), 0);

    // Async reset between edges mid-RUN, then a full MULT
    @(negedge clk);
    drive_mc(1'b0);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("ar_busy_pre", int'(busy), 1);
    #1;
    valid = 1'b0;
    rst   = 1'b1;
    #1;
    chk("ar_busy", int'(busy), 0);
    chk("ar_done", int'(done), 0);
    chk("ar_stall", int'(stall), 0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    for (int k = 0; k < 5; k++) idle_check();
    mc_seq(1'b0, 4);
    idle_check();
    chk("sb_empty", done_q.size(), 0);

    // Single-cycle multiply on the MUL_LAT=1 instance
    do_reset();
    @(negedge clk);
    drive_mc(1'b0);
    #1;
    chk("l1_start", int'(start1), 1);
    chk("l1_stall0", int'(stall1), 1);
    @(negedge clk);
    #1;
    chk("l1_done", int'(done1), 1);
    chk("l1_stall1", int'(stall1), 0);
    chk("l1_busy1", int'(busy1), 1);
    chk("l1_start1", int'(start1), 0);
    @(negedge clk);
    valid = 1'b0;
    #1;
    chk("l1_busy2", int'(busy1), 0);
    chk("l1_done2", int'(done1), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
